watchdog_timer: RTL and testbench
=================================

Name: watchdog_timer

Overview:
- DUT-side watchdog that counts down from a programmed value and flags expiry when it is not serviced in time.
- It is the design-side counterpart of the bench timeout trap. The bench loads it, kicks it, and checks that it expires on schedule.
- It sits beside the template DUT. `expired` is the fault indication that the bench and top-level logic consume.

Parameters:
- CNT_WIDTH, 20, width of the counter and load value.
- DEFAULT_LOAD, 1000000, reload used when a load of 0 is requested. Must fit in CNT_WIDTH.

Ports:
- clk  input  1  single clock; everything updates on its rising edge
- rst  input  1  asynchronous, active-high reset
- load_valid  input  1  load request
- load_ready  output  1  load accepted when high together with load_valid
- load_value  input  CNT_WIDTH  countdown start value; 0 selects DEFAULT_LOAD
- kick  input  1  service pulse; reloads the counter while ARMED
- stop  input  1  disarm request
- count  output  CNT_WIDTH  current counter value
- state  output  2  0=IDLE, 1=ARMED, 2=EXPIRED; 3 is never produced
- expired  output  1  sticky expiry flag
- expired_pulse  output  1  one-cycle pulse on the cycle state enters EXPIRED

Behaviour:
- Reset: state=IDLE, count=0, reload register=DEFAULT_LOAD, expired=0, expired_pulse=0.
  - load_ready is combinational and is 1 from the moment reset asserts.
  - Reset asserted mid-count clears all state immediately, without waiting for a clock edge.
- load_ready=1 in IDLE and EXPIRED; 0 in ARMED.
- Load handshake fires when load_valid & load_ready are both high at a rising edge. On that edge:
  - reload register ← (load_value==0 ? DEFAULT_LOAD : load_value);
  - count ← same value;
  - state → ARMED;
  - expired ← 0.
- ARMED, per cycle, priority stop > kick > decrement:
  - stop: state → IDLE, count holds its current value.
  - kick: count ← reload register.
  - Otherwise, count ← count−1.
  - When count==1 and neither stop nor kick is high, the next edge gives count=0, state=EXPIRED, expired=1, and expired_pulse=1 for exactly that cycle.
- Latency:
  - A load of N with no kicks enters EXPIRED exactly N cycles after the load edge.
  - A kick restarts the full N-cycle interval from that edge.
- EXPIRED:
  - count stays at 0 and expired stays at 1.
  - kick and stop are ignored.
  - Only a new load handshake (or reset) leaves this state.
- IDLE: kick is ignored; count holds.
- Simultaneous events:
  - stop and kick together in ARMED: stop wins.
  - kick on the cycle count==1: reload wins and no expiry occurs.
  - load_valid while ARMED: not accepted (load_ready=0); the request stays pending until the block returns to IDLE or EXPIRED.
- Arithmetic: unsigned. count never wraps below 0, because the decrement is gated by the ARMED state.

Optional Feature:
- Macro WDT_KICK_WINDOW_EN enables a windowed watchdog.
- With the macro defined:
  - Extra output port `early_fault` (1 bit), reset 0.
  - A kick in ARMED is legal only when count ≤ (reload register >> 1).
  - An early kick sends state to EXPIRED on the next edge, with expired=1, a one-cycle expired_pulse, and early_fault=1 (sticky).
  - early_fault clears on the next load handshake.
  - stop still has priority over an early kick.
- Without the macro: the port is absent and a kick is accepted at any count.

Test Plan:
1. Reset then idle → state=0, count=0, expired=0, load_ready=1. Assert rst mid-ARMED at count=37 → every output returns to reset values with no clock edge needed.
2. Load 10, no kicks → count runs 10,9,…,1, then state=2 and count=0 exactly 10 cycles after the load edge. expired_pulse is high for 1 cycle and expired stays 1 afterwards.
3. Load 8, kick at count=1 → count=8 and no expiry. Then leave unkicked → expiry 8 cycles after the kick.
4. Load 0 → count=1000000 on the next cycle. While ARMED, load_valid=1 with load_value=5 → load_ready=0 and count keeps decrementing.
5. ARMED count=20, stop and kick together → state=0, count=20. Then load 3 → expiry after 3 cycles. In EXPIRED, kick is ignored; load 4 clears expired and re-arms.
6. With WDT_KICK_WINDOW_EN: load 100, kick at count=80 → EXPIRED next cycle with early_fault=1. Reload 100, kick at count=50 → count=100 and no fault.

Source files
------------

// File: rtl/watchdog_timer.sv
`default_nettype none
// ============================================================================
// Module   : watchdog_timer
// Brief    : Loadable down-counting watchdog with sticky expiry flag.
//            Define WDT_KICK_WINDOW_EN for a windowed watchdog (early_fault).
// Revision : 1.0
// ============================================================================
module watchdog_timer #(
  parameter int CNT_WIDTH    = 20,
  parameter int DEFAULT_LOAD = 1000000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_valid,
  output logic                 load_ready,
  input  logic [CNT_WIDTH-1:0] load_value,
  input  logic                 kick,
  input  logic                 stop,
  output logic [CNT_WIDTH-1:0] count,
  output logic [1:0]           state,
  output logic                 expired,
  output logic                 expired_pulse
`ifdef WDT_KICK_WINDOW_EN
  ,
  output logic                 early_fault
`endif
);

  localparam logic [CNT_WIDTH-1:0] C_DEFAULT_LOAD = CNT_WIDTH'(DEFAULT_LOAD);
  localparam logic [CNT_WIDTH-1:0] C_ONE          = CNT_WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    EXPIRED = 2'd2
  } state_t;

  state_t               r_state;
  logic [CNT_WIDTH-1:0] r_count;
  logic [CNT_WIDTH-1:0] r_reload;
  logic                 r_expired;
  logic                 r_pulse;
  logic [CNT_WIDTH-1:0] w_load_eff;

  assign w_load_eff = (load_value == '0) ? C_DEFAULT_LOAD : load_value;

  // Combinational so the handshake is open as soon as reset forces IDLE.
  assign load_ready    = (r_state != ARMED);
  assign count         = r_count;
  assign state         = r_state;
  assign expired       = r_expired;
  assign expired_pulse = r_pulse;

`ifdef WDT_KICK_WINDOW_EN
  logic                 r_early;
  logic                 w_kick_early;

  assign w_kick_early = (r_count > (r_reload >> 1));
  assign early_fault  = r_early;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_count   <= '0;
      r_reload  <= C_DEFAULT_LOAD;
      r_expired <= 1'b0;
      r_pulse   <= 1'b0;
`ifdef WDT_KICK_WINDOW_EN
      r_early   <= 1'b0;
`endif
    end else begin
      r_pulse <= 1'b0;
      case (r_state)
        ARMED: begin
          if (stop) begin
            r_state <= IDLE;
          end else if (kick) begin
`ifdef WDT_KICK_WINDOW_EN
            if (w_kick_early) begin
              r_state   <= EXPIRED;
              r_count   <= '0;
              r_expired <= 1'b1;
              r_pulse   <= 1'b1;
              r_early   <= 1'b1;
            end else begin
              r_count <= r_reload;
            end
`else
            r_count <= r_reload;
`endif
          end else if (r_count <= C_ONE) begin
            // Final tick: expiry lands exactly reload cycles after service.
            r_state   <= EXPIRED;
            r_count   <= '0;
            r_expired <= 1'b1;
            r_pulse   <= 1'b1;
          end else begin
            r_count <= r_count - C_ONE;
          end
        end
        IDLE, EXPIRED: begin
          if (load_valid) begin
            r_reload  <= w_load_eff;
            r_count   <= w_load_eff;
            r_state   <= ARMED;
            r_expired <= 1'b0;
`ifdef WDT_KICK_WINDOW_EN
            r_early   <= 1'b0;
`endif
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_watchdog_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_watchdog_timer
// Brief    : Directed + random checks of watchdog_timer against a deadline model.
// Revision : 1.0
// ============================================================================
module tb_watchdog_timer;

  localparam int W   = 20;
  localparam int DEF = 1000000;

  logic         clk = 1'b0;
  logic         rst;
  logic         load_valid;
  logic         load_ready;
  logic [W-1:0] load_value;
  logic         kick;
  logic         stop;
  logic [W-1:0] count;
  logic [1:0]   state;
  logic         expired;
  logic         expired_pulse;
`ifdef WDT_KICK_WINDOW_EN
  logic         early_fault;
`endif

  watchdog_timer #(.CNT_WIDTH(W), .DEFAULT_LOAD(DEF)) dut (
    .clk           (clk),
    .rst           (rst),
    .load_valid    (load_valid),
    .load_ready    (load_ready),
    .load_value    (load_value),
    .kick          (kick),
    .stop          (stop),
    .count         (count),
    .state         (state),
    .expired       (expired),
    .expired_pulse (expired_pulse)
`ifdef WDT_KICK_WINDOW_EN
    ,
    .early_fault   (early_fault)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: while armed, count is the distance from now to an absolute deadline.
  int     m_mode;      // 0 idle, 1 armed, 2 expired
  longint m_cyc;
  longint m_deadline;
  int     m_held;
  int     m_reload;
  bit     m_exp;
  bit     m_pulse;
  bit     m_early;

  function automatic int m_count();
    if (m_mode == 1) return int'(m_deadline - m_cyc);
    if (m_mode == 0) return m_held;
    return 0;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_held = 0; m_reload = DEF;
    m_exp = 0; m_pulse = 0; m_early = 0;
  endtask

  task automatic model_edge();
    int now;
    now = m_count();
    m_cyc++;
    m_pulse = 0;
    if (m_mode == 1) begin
      if (stop) begin
        m_held = now;
        m_mode = 0;
      end else if (kick) begin
`ifdef WDT_KICK_WINDOW_EN
        if (now > m_reload / 2) begin
          m_mode = 2; m_exp = 1; m_pulse = 1; m_early = 1;
        end else
`endif
        m_deadline = m_cyc + m_reload;
      end else if (m_deadline == m_cyc) begin
        m_mode = 2; m_exp = 1; m_pulse = 1;
      end
    end else if (load_valid) begin
      m_reload   = (load_value == '0) ? DEF : int'(load_value);
      m_deadline = m_cyc + m_reload;
      m_mode     = 1;
      m_exp      = 0;
      m_early    = 0;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".count"},      32'(count),         32'(m_count()));
    check({tag, ".state"},      32'(state),         32'(m_mode));
    check({tag, ".expired"},    32'(expired),       32'(m_exp));
    check({tag, ".pulse"},      32'(expired_pulse), 32'(m_pulse));
    check({tag, ".load_ready"}, 32'(load_ready),    32'(m_mode != 1));
`ifdef WDT_KICK_WINDOW_EN
    check({tag, ".early_fault"}, 32'(early_fault),  32'(m_early));
`endif
  endtask

  // Called at a falling edge: drive, take one rising edge, check at the next fall.
  task automatic tick(input string tag, input bit lv, input int val, input bit k, input bit s);
    load_valid = lv;
    load_value = val[W-1:0];
    kick       = k;
    stop       = s;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic idle_ticks(input string tag, input int n);
    for (int i = 0; i < n; i++) tick(tag, 1'b0, 0, 1'b0, 1'b0);
  endtask

  initial begin
    m_cyc = 0;
    m_deadline = 0;
    rst = 1'b1; load_valid = 1'b0; load_value = '0; kick = 1'b0; stop = 1'b0;
    model_reset();
    #1;
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;
    idle_ticks("idle", 2);

    // Plain expiry after 10 cycles
    tick("load10", 1'b1, 10, 1'b0, 1'b0);
    check("load10.count_const", 32'(count), 32'd10);
    for (int i = 1; i <= 9; i++) begin
      tick("run10", 1'b0, 0, 1'b0, 1'b0);
      check("run10.count_const", 32'(count), 32'(10 - i));
    end
    tick("exp10", 1'b0, 0, 1'b0, 1'b0);
    check("exp10.state_const", 32'(state), 32'd2);
    check("exp10.pulse_const", 32'(expired_pulse), 32'd1);
    tick("exp10b", 1'b0, 0, 1'b0, 1'b0);
    check("exp10b.pulse_low", 32'(expired_pulse), 32'd0);
    check("exp10b.sticky", 32'(expired), 32'd1);

    // Kick on the count==1 cycle beats expiry
    tick("load8", 1'b1, 8, 1'b0, 1'b0);
    idle_ticks("run8", 7);
    check("run8.at_one", 32'(count), 32'd1);
    tick("kick8", 1'b0, 0, 1'b1, 1'b0);
    check("kick8.reload", 32'(count), 32'd8);
    idle_ticks("run8b", 7);
    tick("exp8", 1'b0, 0, 1'b0, 1'b0);
    check("exp8.state_const", 32'(state), 32'd2);

    // Zero load selects default; loads refused while armed
    tick("load0", 1'b1, 0, 1'b0, 1'b0);
    check("load0.default", 32'(count), 32'(DEF));
    for (int i = 0; i < 3; i++) tick("pend", 1'b1, 5, 1'b0, 1'b0);
    check("pend.count_const", 32'(count), 32'(DEF - 3));
    check("pend.ready_low", 32'(load_ready), 32'd0);
    tick("stop0", 1'b0, 0, 1'b0, 1'b1);

    // Stop beats kick; idle holds count; expired ignores kick/stop
    tick("load25", 1'b1, 25, 1'b0, 1'b0);
    idle_ticks("run25", 5);
    tick("stopkick", 1'b0, 0, 1'b1, 1'b1);
    check("stopkick.state", 32'(state), 32'd0);
    check("stopkick.count", 32'(count), 32'd20);
    tick("idlekick", 1'b0, 0, 1'b1, 1'b0);
    check("idlekick.count", 32'(count), 32'd20);
    tick("load3", 1'b1, 3, 1'b0, 1'b0);
    idle_ticks("run3", 3);
    check("exp3.state_const", 32'(state), 32'd2);
    tick("expkick", 1'b0, 0, 1'b1, 1'b0);
    tick("expstop", 1'b0, 0, 1'b0, 1'b1);
    check("expkick.state", 32'(state), 32'd2);
    tick("load4", 1'b1, 4, 1'b0, 1'b0);
    check("load4.cleared", 32'(expired), 32'd0);
    check("load4.state", 32'(state), 32'd1);

    // Asynchronous reset in the middle of a countdown
    tick("load50", 1'b1, 50, 1'b0, 1'b1);
    tick("load50b", 1'b1, 50, 1'b0, 1'b0);
    idle_ticks("run50", 13);
    check("run50.at37", 32'(count), 32'd37);
    rst = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    check("async_rst.count_const", 32'(count), 32'd0);
    #1;
    rst = 1'b0;
    tick("post_rst", 1'b0, 0, 1'b0, 1'b0);

`ifdef WDT_KICK_WINDOW_EN
    tick("win_load", 1'b1, 100, 1'b0, 1'b0);
    idle_ticks("win_run", 20);
    check("win_run.at80", 32'(count), 32'd80);
    tick("win_early", 1'b0, 0, 1'b1, 1'b0);
    check("win_early.state", 32'(state), 32'd2);
    check("win_early.fault", 32'(early_fault), 32'd1);
    tick("win_load2", 1'b1, 100, 1'b0, 1'b0);
    idle_ticks("win_run2", 50);
    tick("win_ok", 1'b0, 0, 1'b1, 1'b0);
    check("win_ok.count", 32'(count), 32'd100);
    check("win_ok.fault", 32'(early_fault), 32'd0);
`endif

    // Random traffic, mostly short loads so expiries happen often
    for (int i = 0; i < 600; i++) begin
      bit lv, k, s;
      int v;
      lv = ($urandom % 4) == 0;
      v  = (($urandom % 16) == 0) ? 0 : int'($urandom_range(1, 12));
      k  = ($urandom % 6) == 0;
      s  = ($urandom % 15) == 0;
      tick("rand", lv, v, k, s);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
